rf_wb_port_arbiter: RTL and testbench

- Arbitrates the register file's single write port (a3/wd3/we3) between two sources: the main pipeline MEM/WB writeback and the pipelined multiplier result.
- A multiplier result that collides with a pipeline writeback is buffered in a small in-order queue and retired on a later free cycle; it is no longer dropped or allowed to displace the pipeline write.
- Exports a RAW-hazard flag for decode and a stall request that throttles multiply issue.

---
 rtl/rf_wb_port_arbiter_if.sv | 47 ++++
 rtl/rf_wb_port_arbiter.sv | 133 +++++++++++++
 tb/tb_rf_wb_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_port_arbiter_if.sv
// ============================================================================
// Module      : rf_wb_port_arbiter_if
// Description : Bundles the writeback sources, decode operands and the
//               register-file write port seen by rf_wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_wb_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  i_pipe_we;
  logic [ADDR_WIDTH-1:0] i_pipe_rd;
  logic [DATA_WIDTH-1:0] i_pipe_data;
  logic                  i_mult_valid;
  logic [ADDR_WIDTH-1:0] i_mult_rd;
  logic [DATA_WIDTH-1:0] i_mult_data;
  logic [ADDR_WIDTH-1:0] i_id_rs;
  logic [ADDR_WIDTH-1:0] i_id_rt;
  logic                  o_rf_we;
  logic [ADDR_WIDTH-1:0] o_rf_a3;
  logic [DATA_WIDTH-1:0] o_rf_wd;
  logic                  o_raw_hazard;
  logic                  o_stall_req;
  logic [CNT_W-1:0]      o_count;
  logic                  o_overflow;

  modport master (
    output i_pipe_we, i_pipe_rd, i_pipe_data,
    output i_mult_valid, i_mult_rd, i_mult_data,
    output i_id_rs, i_id_rt,
    input  o_rf_we, o_rf_a3, o_rf_wd, o_raw_hazard, o_stall_req, o_count, o_overflow
  );

  modport slave (
    input  i_pipe_we, i_pipe_rd, i_pipe_data,
    input  i_mult_valid, i_mult_rd, i_mult_data,
    input  i_id_rs, i_id_rt,
    output o_rf_we, o_rf_a3, o_rf_wd, o_raw_hazard, o_stall_req, o_count, o_overflow
  );
endinterface

`default_nettype wire

// File: rtl/rf_wb_port_arbiter.sv
// ============================================================================
// Module      : rf_wb_port_arbiter
// Description : Shares the register-file write port between pipeline WB and
//               the multiplier, queueing colliding multiplier results in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 2
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst_n,
  rf_wb_port_arbiter_if.slave  wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;

  logic                  w_pipe_w;
  logic                  w_mult_w;
  logic                  w_not_empty;
  logic                  w_full;
  logic                  w_head_valid;
  logic                  w_head_invalid;
  logic                  w_bypass;
  logic                  w_pop;
  logic                  w_enq_req;
  logic                  w_enq;
  logic                  w_drop;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_a3;
  logic [DATA_WIDTH-1:0] w_wd;
  logic                  w_hit_rs;
  logic                  w_hit_rt;

  assign w_pipe_w       = wb.i_pipe_we    && (wb.i_pipe_rd != '0);
  assign w_mult_w       = wb.i_mult_valid && (wb.i_mult_rd != '0);
  assign w_not_empty    = (r_count != '0);
  assign w_full         = (r_count == CNT_W'(DEPTH));
  assign w_head_valid   = w_not_empty &&  r_valid[r_head];
  assign w_head_invalid = w_not_empty && !r_valid[r_head];

  // A killed head is discarded even while the pipeline owns the port.
  assign w_bypass  = !w_pipe_w && !w_not_empty && w_mult_w;
  assign w_pop     = w_head_invalid || (!w_pipe_w && w_head_valid);
  assign w_enq_req = w_mult_w && !w_bypass;
  assign w_enq     = w_enq_req && (!w_full || w_pop);
  assign w_drop    = w_enq_req &&  w_full && !w_pop;

  always_comb begin
    w_we = 1'b0;
    w_a3 = '0;
    w_wd = '0;
    if (w_pipe_w) begin
      w_we = 1'b1;
      w_a3 = wb.i_pipe_rd;
      w_wd = wb.i_pipe_data;
    end else if (w_head_valid) begin
      w_we = 1'b1;
      w_a3 = r_rd[r_head];
      w_wd = r_data[r_head];
    end else if (w_bypass) begin
      w_we = 1'b1;
      w_a3 = wb.i_mult_rd;
      w_wd = wb.i_mult_data;
    end
  end

  always_comb begin
    w_hit_rs = w_enq && (wb.i_mult_rd == wb.i_id_rs);
    w_hit_rt = w_enq && (wb.i_mult_rd == wb.i_id_rt);
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_rd[i] == wb.i_id_rs)) w_hit_rs = 1'b1;
      if (r_valid[i] && (r_rd[i] == wb.i_id_rt)) w_hit_rt = 1'b1;
    end
  end

  assign wb.o_rf_we      = w_we;
  assign wb.o_rf_a3      = w_a3;
  assign wb.o_rf_wd      = w_wd;
  assign wb.o_raw_hazard = ((wb.i_id_rs != '0) && w_hit_rs) || ((wb.i_id_rt != '0) && w_hit_rt);
  assign wb.o_stall_req  = (r_count >= CNT_W'(STALL_THRESH));
  assign wb.o_count      = r_count;
  assign wb.o_overflow   = r_overflow;

  // Later assignments win: kill, then pop, then enqueue (tail may equal head when full).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_pipe_w) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_rd[i] == wb.i_pipe_rd) r_valid[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_rd[r_tail]    <= wb.i_mult_rd;
        r_data[r_tail]  <= wb.i_mult_data;
        r_tail          <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_port_arbiter.sv
// ============================================================================
// Module      : tb_rf_wb_port_arbiter
// Description : Directed and randomized checks of rf_wb_port_arbiter against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int THR   = 2;

  typedef struct {
    logic          v;
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

  rf_wb_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .STALL_THRESH(THR)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .wb      (bus.slave)
  );

  ent_t          q[$];
  logic          m_ovf = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;
  logic          last_we;
  logic [AW-1:0] last_a3;
  logic [DW-1:0] last_wd;
  logic          saw_aa;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.i_pipe_we = 1'b0; bus.i_pipe_rd = '0; bus.i_pipe_data = '0;
    bus.i_mult_valid = 1'b0; bus.i_mult_rd = '0; bus.i_mult_data = '0;
    bus.i_id_rs = '0; bus.i_id_rt = '0;
  endtask

  // One clock cycle: drive, compare every output with the model, then advance the model.
  task automatic step(input logic pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                      input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    logic          pw, mw, pop, byp, enq, haz, e_we;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    bus.i_pipe_we = pwe; bus.i_pipe_rd = prd; bus.i_pipe_data = pd;
    bus.i_mult_valid = mv; bus.i_mult_rd = mrd; bus.i_mult_data = md;
    bus.i_id_rs = rs; bus.i_id_rt = rt;
    #1;
    pw  = pwe && (prd != 0);
    mw  = mv && (mrd != 0);
    pop = (q.size() > 0) && (!q[0].v || !pw);
    byp = !pw && (q.size() == 0) && mw;
    enq = mw && !byp && ((q.size() < DEPTH) || pop);
    e_we = 1'b0; e_a3 = '0; e_wd = '0;
    if (pw) begin
      e_we = 1'b1; e_a3 = prd; e_wd = pd;
    end else if (q.size() > 0 && q[0].v) begin
      e_we = 1'b1; e_a3 = q[0].rd; e_wd = q[0].d;
    end else if (byp) begin
      e_we = 1'b1; e_a3 = mrd; e_wd = md;
    end
    haz = 1'b0;
    foreach (q[i]) if (q[i].v && ((rs != 0 && q[i].rd == rs) || (rt != 0 && q[i].rd == rt))) haz = 1'b1;
    if (enq && ((rs != 0 && mrd == rs) || (rt != 0 && mrd == rt))) haz = 1'b1;
    check_eq("rf_we", 64'(bus.o_rf_we), 64'(e_we));
    check_eq("rf_a3", 64'(bus.o_rf_a3), 64'(e_a3));
    check_eq("rf_wd", 64'(bus.o_rf_wd), 64'(e_wd));
    check_eq("raw_hazard", 64'(bus.o_raw_hazard), 64'(haz));
    check_eq("count", 64'(bus.o_count), 64'(q.size()));
    check_eq("stall_req", 64'(bus.o_stall_req), 64'(q.size() >= THR));
    check_eq("overflow", 64'(bus.o_overflow), 64'(m_ovf));
    last_we = bus.o_rf_we; last_a3 = bus.o_rf_a3; last_wd = bus.o_rf_wd;
    if (bus.o_rf_we && bus.o_rf_wd == 32'hAA) saw_aa = 1'b1;
    @(posedge clk);
    if (pw) foreach (q[i]) if (q[i].rd == prd) q[i].v = 1'b0;
    if (pop) void'(q.pop_front());
    if (enq) q.push_back('{v: 1'b1, rd: mrd, d: md});
    else if (mw && !byp) m_ovf = 1'b1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive_idle();
    saw_aa = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", 64'(bus.o_count), 64'd0);
    check_eq("rst_we", 64'(bus.o_rf_we), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Bypass straight to the write port
    step(0, 0, 0, 1, 8, 32'h2A, 8, 0);
    check_eq("byp_we", 64'(last_we), 64'd1);
    check_eq("byp_a3", 64'(last_a3), 64'd8);
    check_eq("byp_wd", 64'(last_wd), 64'h2A);

    // Collision: pipeline wins, multiplier result retires next cycle
    step(1, 3, 32'h11, 1, 9, 32'h99, 0, 9);
    check_eq("col_a3", 64'(last_a3), 64'd3);
    idle_step();
    check_eq("col_retire_a3", 64'(last_a3), 64'd9);
    check_eq("col_retire_wd", 64'(last_wd), 64'h99);
    idle_step();

    // WAW kill: queued rd=5 superseded by a younger pipeline write
    step(1, 1, 32'h1, 1, 5, 32'hAA, 5, 0);
    step(1, 5, 32'hBB, 0, 0, 0, 5, 0);
    idle_step();
    check_eq("waw_pop_we", 64'(last_we), 64'd0);
    idle_step();
    check_eq("waw_no_aa", 64'(saw_aa), 64'd0);

    // Fill and overflow, then in-order drain
    for (int i = 0; i < 6; i++) step(1, 1, 32'(i), 1, AW'(10 + i), 32'(32'h100 + i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle_step();
      check_eq("drain_a3", 64'(last_a3), 64'(10 + i));
    end
    check_eq("ovf_sticky", 64'(bus.o_overflow), 64'd1);

    // Zero register handling
    step(0, 0, 0, 1, 0, 32'h5, 0, 0);
    check_eq("zero_mult_we", 64'(last_we), 64'd0);
    step(1, 2, 32'h22, 1, 7, 32'h77, 0, 0);
    step(1, 0, 32'h33, 0, 0, 0, 0, 0);
    check_eq("zero_pipe_head_a3", 64'(last_a3), 64'd7);
    idle_step();

    // Asynchronous reset in the middle of a cycle with entries queued
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, AW'(20 + i), 32'(i), 0, 0);
    @(negedge clk);
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_count", 64'(bus.o_count), 64'd0);
    check_eq("mid_rst_stall", 64'(bus.o_stall_req), 64'd0);
    check_eq("mid_rst_ovf", 64'(bus.o_overflow), 64'd0);
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_step();
      check_eq("post_rst_we", 64'(last_we), 64'd0);
    end

    // Randomized traffic over a small register range to provoke collisions
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 99) < 55), AW'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
